// File: rtl/spi_flash_reader.sv
// spi_flash_reader: SPI mode-0 master that reads one 32-bit word from serial
// flash per read strobe. It sends a READ command plus 24-bit byte address,
// optionally clocks turnaround cells, then shifts in 32 data bits. The word
// is returned byte-swapped to little-endian.
// Optional feature macro: SPI_FLASH_FAST_READ_EN selects FAST READ (0x0B)
// with 8 extra dummy cells.
module spi_flash_reader #(
  parameter int CLK_DIV    = 2,
  parameter int DUMMY_CLKS = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rstrb,
  input  logic [19:0] word_address,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        rbusy,
  output logic        spi_clk,
  output logic        spi_cs_n,
  output logic        spi_mosi,
  input  logic        spi_miso
);

`ifdef SPI_FLASH_FAST_READ_EN
  localparam logic [7:0] CMD_BYTE    = 8'h0B;
  localparam int         DUMMY_CELLS = DUMMY_CLKS + 8;
`else
  localparam logic [7:0] CMD_BYTE    = 8'h03;
  localparam int         DUMMY_CELLS = DUMMY_CLKS;
`endif

  // Divider counts clk cycles inside one bit cell; bit counter counts cells.
  localparam int DW = $clog2(2 * CLK_DIV + 1);
  localparam int BW = $clog2(64 + DUMMY_CLKS + 8 + 1);

  localparam logic [DW-1:0] DIV_LAST   = DW'(2 * CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HIGH   = DW'(CLK_DIV);
  localparam logic [DW-1:0] DIV_ONE    = DW'(1);
  localparam logic [BW-1:0] BIT_ONE    = BW'(1);
  localparam logic [BW-1:0] WORD_LAST  = BW'(31);
  localparam logic [BW-1:0] DUMMY_LAST = BW'(DUMMY_CELLS - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CMD     = 3'd1,
    ST_DUMMY   = 3'd2,
    ST_DATA    = 3'd3,
    ST_RECOVER = 3'd4
  } state_t;

  function automatic logic [31:0] byte_swap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  state_t        state_q, state_d;
  logic          launch_q, launch_d;
  logic [DW-1:0] div_q, div_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [31:0]   shift_q, shift_d;
  logic [31:0]   w_q, w_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          rvalid_q, rvalid_d;
  logic          rbusy_q, rbusy_d;
  logic          spi_clk_q, spi_clk_d;
  logic          spi_cs_n_q, spi_cs_n_d;
  logic          spi_mosi_q, spi_mosi_d;

  logic [DW-1:0] div_inc_s;
  logic          cell_end_s;
  logic [31:0]   w_shift_s;

  // Next-state and next-output logic; launch_q delays the first cell by one
  // cycle so chip select falls on the edge after the strobe is accepted.
  always_comb begin
    state_d    = state_q;
    launch_d   = launch_q;
    div_d      = div_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    w_d        = w_q;
    rdata_d    = rdata_q;
    rvalid_d   = 1'b0;
    rbusy_d    = rbusy_q;
    spi_clk_d  = spi_clk_q;
    spi_cs_n_d = spi_cs_n_q;
    spi_mosi_d = spi_mosi_q;
    div_inc_s  = div_q + DIV_ONE;
    cell_end_s = (div_q == DIV_LAST);
    w_shift_s  = {w_q[30:0], spi_miso};

    case (state_q)
      ST_IDLE: begin
        if (rstrb) begin
          state_d  = ST_CMD;
          launch_d = 1'b1;
          div_d    = {DW{1'b0}};
          bit_d    = {BW{1'b0}};
          shift_d  = {CMD_BYTE, 2'b00, word_address, 2'b00};
          w_d      = 32'h0000_0000;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_CMD: begin
        if (launch_q) begin
          launch_d   = 1'b0;
          rbusy_d    = 1'b1;
          spi_cs_n_d = 1'b0;
          spi_clk_d  = 1'b0;
          spi_mosi_d = shift_q[31];
        end else if (cell_end_s) begin
          div_d     = {DW{1'b0}};
          spi_clk_d = 1'b0;
          shift_d   = {shift_q[30:0], 1'b0};
          if (bit_q == WORD_LAST) begin
            bit_d      = {BW{1'b0}};
            spi_mosi_d = 1'b0;
            state_d    = (DUMMY_CELLS == 0) ? ST_DATA : ST_DUMMY;
          end else begin
            bit_d      = bit_q + BIT_ONE;
            spi_mosi_d = shift_q[30];
          end
        end else begin
          div_d     = div_inc_s;
          spi_clk_d = (div_inc_s >= DIV_HIGH);
        end
      end

      ST_DUMMY: begin
        if (cell_end_s) begin
          div_d     = {DW{1'b0}};
          spi_clk_d = 1'b0;
          if (bit_q == DUMMY_LAST) begin
            bit_d   = {BW{1'b0}};
            state_d = ST_DATA;
          end else begin
            bit_d = bit_q + BIT_ONE;
          end
        end else begin
          div_d     = div_inc_s;
          spi_clk_d = (div_inc_s >= DIV_HIGH);
        end
      end

      ST_DATA: begin
        if (cell_end_s) begin
          div_d     = {DW{1'b0}};
          spi_clk_d = 1'b0;
          w_d       = w_shift_s;
          if (bit_q == WORD_LAST) begin
            bit_d      = {BW{1'b0}};
            state_d    = ST_RECOVER;
            spi_cs_n_d = 1'b1;
            rvalid_d   = 1'b1;
            rdata_d    = byte_swap32(w_shift_s);
          end else begin
            bit_d = bit_q + BIT_ONE;
          end
        end else begin
          div_d     = div_inc_s;
          spi_clk_d = (div_inc_s >= DIV_HIGH);
        end
      end

      ST_RECOVER: begin
        if (cell_end_s) begin
          div_d   = {DW{1'b0}};
          rbusy_d = 1'b0;
          state_d = ST_IDLE;
        end else begin
          div_d = div_inc_s;
        end
      end

      default: begin
        state_d    = ST_IDLE;
        launch_d   = 1'b0;
        rbusy_d    = 1'b0;
        spi_clk_d  = 1'b0;
        spi_cs_n_d = 1'b1;
        spi_mosi_d = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      launch_q   <= 1'b0;
      div_q      <= {DW{1'b0}};
      bit_q      <= {BW{1'b0}};
      shift_q    <= 32'h0000_0000;
      w_q        <= 32'h0000_0000;
      rdata_q    <= 32'h0000_0000;
      rvalid_q   <= 1'b0;
      rbusy_q    <= 1'b0;
      spi_clk_q  <= 1'b0;
      spi_cs_n_q <= 1'b1;
      spi_mosi_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      launch_q   <= launch_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      w_q        <= w_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
      rbusy_q    <= rbusy_d;
      spi_clk_q  <= spi_clk_d;
      spi_cs_n_q <= spi_cs_n_d;
      spi_mosi_q <= spi_mosi_d;
    end
  end

  assign rdata    = rdata_q;
  assign rvalid   = rvalid_q;
  assign rbusy    = rbusy_q;
  assign spi_clk  = spi_clk_q;
  assign spi_cs_n = spi_cs_n_q;
  assign spi_mosi = spi_mosi_q;

endmodule

// File: tb/tb_spi_flash_reader.sv
// Self-checking bench for spi_flash_reader. A behavioural flash (byte array
// defined by a hash function) answers on spi_miso; each read is judged by
// cycle numbers taken from the timing formulas and by little-endian byte
// assembly of the addressed flash bytes.
`timescale 1ns/1ps
module tb_spi_flash_reader;

  localparam int CLK_DIV    = 2;
  localparam int DUMMY_CLKS = 1;
`ifdef SPI_FLASH_FAST_READ_EN
  localparam logic [7:0] CMD = 8'h0B;
  localparam int         D   = DUMMY_CLKS + 8;
`else
  localparam logic [7:0] CMD = 8'h03;
  localparam int         D   = DUMMY_CLKS;
`endif
  localparam int CELL       = 2 * CLK_DIV;
  localparam int LAT        = 1 + (64 + D) * CELL;
  localparam int DATA_START = 1 + (32 + D) * CELL;

  logic        clk = 1'b0;
  logic        reset, rstrb, spi_miso;
  logic [19:0] word_address;
  logic [31:0] rdata;
  logic        rvalid, rbusy, spi_clk, spi_cs_n, spi_mosi;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] seed;

  always #5 clk = ~clk;

  spi_flash_reader #(.CLK_DIV(CLK_DIV), .DUMMY_CLKS(DUMMY_CLKS)) dut (
    .clk(clk), .reset(reset), .rstrb(rstrb), .word_address(word_address),
    .rdata(rdata), .rvalid(rvalid), .rbusy(rbusy), .spi_clk(spi_clk),
    .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );

  // Flash contents: fixed boot bytes at 0..3, pseudo-random elsewhere.
  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    logic [31:0] h;
    case (a)
      24'd0:   return 8'hB7;
      24'd1:   return 8'h01;
      24'd2:   return 8'h40;
      24'd3:   return 8'h00;
      default: begin
        h = ({8'h00, a} * 32'h9E37_79B1) ^ seed;
        return h[31:24] ^ h[15:8];
      end
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_state(input string where);
    chk({where, "_cs_n"},   32'(spi_cs_n), 32'd1);
    chk({where, "_sclk"},   32'(spi_clk),  32'd0);
    chk({where, "_mosi"},   32'(spi_mosi), 32'd0);
    chk({where, "_rbusy"},  32'(rbusy),    32'd0);
    chk({where, "_rvalid"}, 32'(rvalid),   32'd0);
    chk({where, "_rdata"},  rdata,         32'd0);
  endtask

  // One read; optional stray strobes at cycles stray_a/stray_b, optional
  // reset of rst_len cycles driven from cycle rst_at. Cycle n is observed
  // 1 ns after edge n; edge 0 is the edge that samples the strobe.
  task automatic read_txn(input logic [19:0] addr, input int stray_a, input int stray_b,
                          input int rst_at, input int rst_len, input int tail);
    int n, rises, nz, cs_low, first_low, rv_cycle, rv_count, fall_cycle;
    int clk_hi_cs, cs_low_after_rst, k, limit;
    logic prev_sclk, done;
    logic [31:0] cmd_w, stream, exp_data, rv_data;
    logic [23:0] eb;
    eb = {2'b00, addr, 2'b00};
    exp_data = {flash_byte(eb + 24'd3), flash_byte(eb + 24'd2),
                flash_byte(eb + 24'd1), flash_byte(eb)};
    rises = 0; nz = 0; cs_low = 0; first_low = -1; rv_cycle = -1; rv_count = 0;
    fall_cycle = -1; clk_hi_cs = 0; cs_low_after_rst = 0;
    cmd_w = 32'd0; stream = 32'd0; rv_data = 32'd0; prev_sclk = 1'b0; done = 1'b0;
    limit = (rst_at >= 0) ? rst_at + rst_len + 40 : LAT + CELL + 30;
    word_address = addr;
    rstrb = 1'b1;
    @(posedge clk); #1;
    rstrb = 1'b0;
    n = 0;
    while (!done) begin
      if (!spi_cs_n) begin
        cs_low++;
        if (first_low < 0) first_low = n;
        if (rst_at >= 0 && n > rst_at) cs_low_after_rst++;
      end
      if (spi_cs_n && spi_clk) clk_hi_cs++;
      if (rvalid) begin
        rv_count++;
        if (rv_cycle < 0) begin rv_cycle = n; rv_data = rdata; end
      end
      if (rv_cycle >= 0 && fall_cycle < 0 && !rbusy) fall_cycle = n;
      // Flash side: capture MOSI and present the next MISO bit on each rise.
      if (spi_clk && !prev_sclk && !spi_cs_n) begin
        rises++;
        if (rises <= 32) cmd_w = {cmd_w[30:0], spi_mosi};
        else if (spi_mosi) nz++;
        if (rises == 32)
          stream = {flash_byte(cmd_w[23:0]), flash_byte(cmd_w[23:0] + 24'd1),
                    flash_byte(cmd_w[23:0] + 24'd2), flash_byte(cmd_w[23:0] + 24'd3)};
        if (rises > 32 + D && rises <= 64 + D) begin
          k = rises - 33 - D;
          spi_miso = stream[31 - k];
        end else begin
          spi_miso = 1'($urandom);
        end
      end
      prev_sclk = spi_clk;
      if (rst_at >= 0 && n == rst_at + 1) chk("rst_cs_n_next", 32'(spi_cs_n), 32'd1);
      if (rst_at >= 0 && n == rst_at + rst_len) chk_reset_state("rst_mid");
      rstrb = (n == stray_a || n == stray_b);
      if (rst_at >= 0) reset = (n >= rst_at && n < rst_at + rst_len);
      if (fall_cycle >= 0 && n >= fall_cycle + tail) done = 1'b1;
      if (n >= limit) done = 1'b1;
      if (!done) begin
        @(posedge clk); #1;
        n++;
      end
    end
    rstrb = 1'b0;
    reset = 1'b0;
    if (rst_at >= 0) begin
      chk("rst_no_rvalid", 32'(rv_count), 32'd0);
      chk("rst_cs_stays_high", 32'(cs_low_after_rst), 32'd0);
    end else begin
      chk("cs_fall_edge", 32'(first_low), 32'd1);
      chk("mosi_cmd", cmd_w, {CMD, 2'b00, addr, 2'b00});
      chk("mosi_zero_after_cmd", 32'(nz), 32'd0);
      chk("sclk_rises", 32'(rises), 32'(64 + D));
      chk("cs_low_cycles", 32'(cs_low), 32'(LAT - 1));
      chk("rvalid_edge", 32'(rv_cycle), 32'(LAT));
      chk("rvalid_pulses", 32'(rv_count), 32'd1);
      chk("rdata", rv_data, exp_data);
      chk("rbusy_fall_edge", 32'(fall_cycle), 32'(LAT + CELL));
      chk("sclk_low_when_cs_high", 32'(clk_hi_cs), 32'd0);
      chk("rdata_held", rdata, exp_data);
    end
  endtask

  initial begin
    seed = $urandom;
    reset = 1'b1;
    rstrb = 1'b0;
    word_address = 20'd0;
    spi_miso = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk_reset_state("por");

    // Boot word and address encoding.
    read_txn(20'h00000, -1, -1, -1, 0, 5);
    read_txn(20'h00002, -1, -1, -1, 0, 5);

    // Strobes during DATA and in the rvalid cycle are dropped.
    read_txn(20'($urandom), DATA_START + 20, LAT, -1, 0, 20);

    // Back-to-back reads at the minimum period.
    read_txn(20'($urandom), -1, -1, -1, 0, 0);
    read_txn(20'($urandom), -1, -1, -1, 0, 0);
    read_txn(20'($urandom), -1, -1, -1, 0, 3);

    // Three-cycle reset mid-command, then a normal read.
    read_txn(20'($urandom), -1, -1, 50, 3, 0);
    read_txn(20'($urandom), -1, -1, -1, 0, 3);

    // Reset during DATA bit 10, then word 1.
    read_txn(20'($urandom), -1, -1, DATA_START + 10 * CELL + 1, 1, 0);
    read_txn(20'h00001, -1, -1, -1, 0, 3);

    // Random addresses.
    for (int i = 0; i < 4; i++) read_txn(20'($urandom), -1, -1, -1, 0, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
